ahb_access_scheduler: RTL and testbench



---
 rtl/ahb_access_scheduler_pkg.sv | 28 ++
 rtl/ahb_access_scheduler_if.sv | 43 ++++
 rtl/ahb_access_scheduler_addr_counter.sv | 53 +++++
 rtl/ahb_access_scheduler.sv | 128 ++++++++++++
 tb/tb_ahb_access_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_access_scheduler_pkg.sv
// Shared types and constants for the AHB access scheduler.
package ahb_access_scheduler_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    RD_BUSY = 3'd2,
    WR_BUSY = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } grant_t;

  // Round-robin pick: with both sides eligible the side that did not win
  // last time goes next; otherwise the only eligible side wins. The result
  // is meaningless when neither side is eligible, so callers gate on that.
  function automatic grant_t pick_grant(logic rd_ok, logic wr_ok, grant_t last);
    if (rd_ok && wr_ok) return (last == RD) ? WR : RD;
    if (wr_ok) return WR;
    return RD;
  endfunction

endpackage

// File: rtl/ahb_access_scheduler_if.sv
// Bundle of request, completion and AHB-master control signals.
//
// Handshake: i_rd_req / i_wr_req are levels saying a side has work. Once a
// side is granted, o_re (or o_we) rises and stays high with a stable
// address until the matching i_read_complete (or i_write_complete) is
// sampled high on a clock edge; that edge ends the transfer, drops the
// request and produces a one-cycle o_rd_done (or o_wr_done).
interface ahb_access_scheduler_if;
  import ahb_access_scheduler_pkg::*;

  logic              i_start;
  logic              i_abort;
  logic              i_rd_req;
  logic              i_wr_req;
  logic              i_read_complete;
  logic              i_write_complete;
  logic              o_re;
  logic              o_we;
  logic [ADDR_W-1:0] o_raddr;
  logic [ADDR_W-1:0] o_waddr;
  logic              o_rd_done;
  logic              o_wr_done;
  logic              o_busy;
  logic              o_frame_done;
  sched_state_t      dbg_state;
  logic [ADDR_W-1:0] dbg_rd_idx;
  logic [ADDR_W-1:0] dbg_wr_idx;

  // Scheduler side
  modport master (
    input  i_start, i_abort, i_rd_req, i_wr_req, i_read_complete, i_write_complete,
    output o_re, o_we, o_raddr, o_waddr, o_rd_done, o_wr_done, o_busy, o_frame_done,
    output dbg_state, dbg_rd_idx, dbg_wr_idx
  );

  // Environment side (sequencer, fetch/writeback, AHB master)
  modport slave (
    output i_start, i_abort, i_rd_req, i_wr_req, i_read_complete, i_write_complete,
    input  o_re, o_we, o_raddr, o_waddr, o_rd_done, o_wr_done, o_busy, o_frame_done,
    input  dbg_state, dbg_rd_idx, dbg_wr_idx
  );

endinterface

// File: rtl/ahb_access_scheduler_addr_counter.sv
// Transfer index counter with a registered raster byte address alongside.
module ahb_access_scheduler_addr_counter
  import ahb_access_scheduler_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int unsigned       STRIDE = 4,
  parameter int unsigned       LIMIT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              at_limit_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LIMIT);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Address tracks index incrementally so it is a register, not an adder
  // output; it wraps modulo 2^32 on its own.
  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (clr_i) begin
      idx_d  = '0;
      addr_d = BASE;
    end else if (inc_i && !at_limit_o) begin
      idx_d  = idx_q + ADDR_W'(1);
      addr_d = addr_q + STEP;
    end
  end

  // Index/address state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      addr_q <= BASE;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign idx_o      = idx_q;
  assign addr_o     = addr_q;
  assign at_limit_o = (idx_q == LAST);

endmodule

// File: rtl/ahb_access_scheduler.sv
// Round-robin sharing of one AHB master between pixel fetch (reads) and
// result writeback (writes) over one raster frame.
module ahb_access_scheduler
  import ahb_access_scheduler_pkg::*;
#(
  parameter int unsigned       IMG_W   = 640,
  parameter int unsigned       IMG_H   = 480,
  parameter logic [ADDR_W-1:0] RD_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] WR_BASE = 32'h0010_0000,
  parameter int unsigned       STRIDE  = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,   // active-high despite the name
  ahb_access_scheduler_if.master bus
);

  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned NWORDS = IMG_W * IMG_H / 4;

  sched_state_t state_q, state_d;
  grant_t       last_q, last_d;
  grant_t       grant;
  logic         re_q, we_q, rd_done_q, wr_done_q, busy_q, frame_done_q;
  logic         rd_done_d, wr_done_d;
  logic         rd_clr, wr_clr, rd_inc, wr_inc;
  logic         rd_at_limit, wr_at_limit;
  logic         rd_ok, wr_ok;

  ahb_access_scheduler_addr_counter #(
    .BASE(RD_BASE), .STRIDE(STRIDE), .LIMIT(NPIX)
  ) u_rd_cnt (
    .clk(clk), .rst(n_rst), .clr_i(rd_clr), .inc_i(rd_inc),
    .idx_o(bus.dbg_rd_idx), .addr_o(bus.o_raddr), .at_limit_o(rd_at_limit)
  );

  ahb_access_scheduler_addr_counter #(
    .BASE(WR_BASE), .STRIDE(STRIDE), .LIMIT(NWORDS)
  ) u_wr_cnt (
    .clk(clk), .rst(n_rst), .clr_i(wr_clr), .inc_i(wr_inc),
    .idx_o(bus.dbg_wr_idx), .addr_o(bus.o_waddr), .at_limit_o(wr_at_limit)
  );

  assign rd_ok = bus.i_rd_req && !rd_at_limit;
  assign wr_ok = bus.i_wr_req && !wr_at_limit;
  assign grant = pick_grant(rd_ok, wr_ok, last_q);

  // Next state, counter control and done pulses; abort overrides everything
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rd_clr    = 1'b0;
    wr_clr    = 1'b0;
    rd_inc    = 1'b0;
    wr_inc    = 1'b0;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    if (bus.i_abort) begin
      state_d = IDLE;
      rd_clr  = 1'b1;
      wr_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            state_d = ARB;
            rd_clr  = 1'b1;
            wr_clr  = 1'b1;
            last_d  = WR;   // first contended grant goes to reads
          end
        end
        ARB: begin
          if (rd_at_limit && wr_at_limit) state_d = DONE;
          else if (rd_ok || wr_ok)        state_d = (grant == RD) ? RD_BUSY : WR_BUSY;
        end
        RD_BUSY: begin
          if (bus.i_read_complete) begin
            state_d   = ARB;
            rd_inc    = 1'b1;
            rd_done_d = 1'b1;
            last_d    = RD;
          end
        end
        WR_BUSY: begin
          if (bus.i_write_complete) begin
            state_d   = ARB;
            wr_inc    = 1'b1;
            wr_done_d = 1'b1;
            last_d    = WR;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; bus strobes follow the state being entered
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q      <= IDLE;
      last_q       <= WR;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      re_q         <= (state_d == RD_BUSY);
      we_q         <= (state_d == WR_BUSY);
      rd_done_q    <= rd_done_d;
      wr_done_q    <= wr_done_d;
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign bus.o_re         = re_q;
  assign bus.o_we         = we_q;
  assign bus.o_rd_done    = rd_done_q;
  assign bus.o_wr_done    = wr_done_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_ahb_access_scheduler.sv
// Bench for ahb_access_scheduler on a 4x2 frame (8 reads, 2 writes).
module tb_ahb_access_scheduler;
  import ahb_access_scheduler_pkg::*;

  localparam int          NPIX    = 8;
  localparam int          NWORDS  = 2;
  localparam int          BUDGET  = 400;
  localparam logic [31:0] RD_BASE = 32'h0000_0000;
  localparam logic [31:0] WR_BASE = 32'h0010_0000;

  logic clk = 1'b0;
  logic n_rst;

  ahb_access_scheduler_if bus ();

  ahb_access_scheduler #(
    .IMG_W(4), .IMG_H(2), .RD_BASE(RD_BASE), .WR_BASE(WR_BASE), .STRIDE(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: {is_write, byte address} per granted transfer, in order
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.i_start          = 1'b0;
    bus.i_abort          = 1'b0;
    bus.i_rd_req         = 1'b0;
    bus.i_wr_req         = 1'b0;
    bus.i_read_complete  = 1'b0;
    bus.i_write_complete = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
  endtask

  // Reference model: transfer order from the arbitration rules alone
  task automatic model_frame(input bit rd_on, input bit wr_on);
    int rd_left, wr_left, ri, wi;
    bit last_wr, pick_wr;
    rd_left = rd_on ? NPIX : 0;
    wr_left = wr_on ? NWORDS : 0;
    ri = 0; wi = 0; last_wr = 1'b1;
    while (rd_left > 0 || wr_left > 0) begin
      if (rd_left > 0 && wr_left > 0) pick_wr = !last_wr;
      else                            pick_wr = (wr_left > 0);
      if (pick_wr) begin
        exp_q.push_back({1'b1, WR_BASE + 32'(4 * wi)});
        wi++; wr_left--;
      end else begin
        exp_q.push_back({1'b0, RD_BASE + 32'(4 * ri)});
        ri++; rd_left--;
      end
      last_wr = pick_wr;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_re, bus.o_we, bus.o_rd_done, bus.o_wr_done, bus.o_busy, bus.o_frame_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000",
        {bus.o_re, bus.o_we, bus.o_rd_done, bus.o_wr_done, bus.o_busy, bus.o_frame_done});
    end else n_pass++;
    n_checks++;
    if (bus.o_raddr !== RD_BASE || bus.o_waddr !== WR_BASE) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h want %h/%h", bus.o_raddr, bus.o_waddr, RD_BASE, WR_BASE);
    end else n_pass++;
    n_checks++;
    if (bus.dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE);
    end else n_pass++;
  endtask

  // Runs one frame with held request levels and an automatic completion
  // responder; noise adds random wrong-side completions, including ones
  // coinciding with the real completion.
  task automatic run_frame(input bit rd_on, input bit wr_on, input bit noise, input string tag);
    int cyc, last_cmpl, rd_cmpl, wr_cmpl, rd_age, wr_age, rd_dly, wr_dly;
    int xfers, total, fd_cnt, fd_cyc, rd_dones, wr_dones;
    bit rd_act, wr_act, finished, expect_frame;
    logic [31:0] rd_a, wr_a;
    logic [32:0] got, want;
    exp_q.delete();
    model_frame(rd_on, wr_on);
    total = exp_q.size();
    expect_frame = rd_on && wr_on;
    last_cmpl = 0; rd_cmpl = -10; wr_cmpl = -10; rd_age = 0; wr_age = 0;
    rd_dly = 2; wr_dly = 2; xfers = 0; fd_cnt = 0; fd_cyc = -10;
    rd_dones = 0; wr_dones = 0; rd_act = 0; wr_act = 0; finished = 0;
    rd_a = '0; wr_a = '0;
    @(negedge clk);
    bus.i_rd_req = rd_on;
    bus.i_wr_req = wr_on;
    bus.i_start  = 1'b1;
    cyc = 0;
    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      bus.i_start          = 1'b0;
      bus.i_read_complete  = 1'b0;
      bus.i_write_complete = 1'b0;
      if (cyc == 1) begin
        n_checks++;
        if (bus.o_busy !== 1'b1 || bus.dbg_state !== ARB) begin
          n_fail++; $display("FAIL %s start_busy: got busy=%b state=%0d want 1/%0d", tag, bus.o_busy, bus.dbg_state, ARB);
        end else n_pass++;
      end
      n_checks++;
      if (bus.o_re && bus.o_we) begin
        n_fail++; $display("FAIL %s exclusive: got re=1 we=1 want at most one", tag);
      end else n_pass++;
      if (bus.o_rd_done) begin
        rd_dones++;
        n_checks++;
        if (cyc !== rd_cmpl + 1 || bus.o_re !== 1'b0 || bus.dbg_wr_idx !== 32'(wr_dones)) begin
          n_fail++; $display("FAIL %s rd_done: got cyc=%0d re=%b wr_idx=%0d want cyc=%0d re=0 wr_idx=%0d",
            tag, cyc, bus.o_re, bus.dbg_wr_idx, rd_cmpl + 1, wr_dones);
        end else n_pass++;
      end
      if (bus.o_wr_done) begin
        wr_dones++;
        n_checks++;
        if (cyc !== wr_cmpl + 1 || bus.o_we !== 1'b0) begin
          n_fail++; $display("FAIL %s wr_done: got cyc=%0d we=%b want cyc=%0d we=0", tag, cyc, bus.o_we, wr_cmpl + 1);
        end else n_pass++;
      end
      if (bus.o_frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        n_checks++;
        if (!expect_frame || xfers != total || cyc != last_cmpl + 2) begin
          n_fail++; $display("FAIL %s frame_done: got cyc=%0d xfers=%0d want cyc=%0d xfers=%0d expected=%b",
            tag, cyc, xfers, last_cmpl + 2, total, expect_frame);
        end else n_pass++;
      end
      if (bus.o_re) begin
        if (!rd_act) begin
          rd_act = 1'b1; rd_age = 0; rd_a = bus.o_raddr; xfers++;
          rd_dly = noise ? int'($urandom_range(1, 4)) : 2;
          got = {1'b0, rd_a};
          n_checks++;
          if (cyc != last_cmpl + 2) begin
            n_fail++; $display("FAIL %s rd_latency: got cyc=%0d want %0d", tag, cyc, last_cmpl + 2);
          end else n_pass++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s extra_xfer: got %h want none", tag, got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++; $display("FAIL %s xfer_order: got %h want %h", tag, got, want);
            end else n_pass++;
          end
        end else begin
          n_checks++;
          if (bus.o_raddr !== rd_a) begin
            n_fail++; $display("FAIL %s raddr_stable: got %h want %h", tag, bus.o_raddr, rd_a);
          end else n_pass++;
        end
        rd_age++;
        if (noise) bus.i_write_complete = 1'($urandom_range(0, 1));
        if (rd_age == rd_dly) begin
          bus.i_read_complete = 1'b1; rd_act = 1'b0; rd_cmpl = cyc; last_cmpl = cyc;
        end
      end
      if (bus.o_we) begin
        if (!wr_act) begin
          wr_act = 1'b1; wr_age = 0; wr_a = bus.o_waddr; xfers++;
          wr_dly = noise ? int'($urandom_range(1, 4)) : 2;
          got = {1'b1, wr_a};
          n_checks++;
          if (cyc != last_cmpl + 2) begin
            n_fail++; $display("FAIL %s wr_latency: got cyc=%0d want %0d", tag, cyc, last_cmpl + 2);
          end else n_pass++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s extra_xfer: got %h want none", tag, got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++; $display("FAIL %s xfer_order: got %h want %h", tag, got, want);
            end else n_pass++;
          end
        end else begin
          n_checks++;
          if (bus.o_waddr !== wr_a) begin
            n_fail++; $display("FAIL %s waddr_stable: got %h want %h", tag, bus.o_waddr, wr_a);
          end else n_pass++;
        end
        wr_age++;
        if (noise) bus.i_read_complete = 1'($urandom_range(0, 1));
        if (wr_age == wr_dly) begin
          bus.i_write_complete = 1'b1; wr_act = 1'b0; wr_cmpl = cyc; last_cmpl = cyc;
        end
      end
      if (expect_frame && fd_cnt > 0 && cyc == fd_cyc + 1) begin
        finished = 1'b1;
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.dbg_state !== IDLE) begin
          n_fail++; $display("FAIL %s idle_after_frame: got busy=%b state=%0d want 0/%0d", tag, bus.o_busy, bus.dbg_state, IDLE);
        end else n_pass++;
      end
      if (!expect_frame && xfers == total && !rd_act && !wr_act && cyc >= last_cmpl + 10) finished = 1'b1;
    end
    bus.i_read_complete  = 1'b0;
    bus.i_write_complete = 1'b0;
    n_checks++;
    if (!finished) begin
      n_fail++; $display("FAIL %s timeout: got %0d cycles want finish within %0d", tag, cyc, BUDGET);
    end else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || rd_dones != (rd_on ? NPIX : 0) || wr_dones != (wr_on ? NWORDS : 0)) begin
      n_fail++; $display("FAIL %s totals: got left=%0d rd=%0d wr=%0d want left=0 rd=%0d wr=%0d",
        tag, exp_q.size(), rd_dones, wr_dones, rd_on ? NPIX : 0, wr_on ? NWORDS : 0);
    end else n_pass++;
    n_checks++;
    if (fd_cnt != (expect_frame ? 1 : 0)) begin
      n_fail++; $display("FAIL %s frame_count: got %0d want %0d", tag, fd_cnt, expect_frame ? 1 : 0);
    end else n_pass++;
    if (!expect_frame) begin
      n_checks++;
      if (bus.o_busy !== 1'b1 || bus.dbg_state !== ARB) begin
        n_fail++; $display("FAIL %s stuck_in_arb: got busy=%b state=%0d want 1/%0d", tag, bus.o_busy, bus.dbg_state, ARB);
      end else n_pass++;
      pulse_abort();
      n_checks++;
      if (bus.dbg_state !== IDLE || bus.o_busy !== 1'b0 || bus.o_raddr !== RD_BASE || bus.o_rd_done !== 1'b0) begin
        n_fail++; $display("FAIL %s abort_idle: got state=%0d busy=%b raddr=%h done=%b want %0d/0/%h/0",
          tag, bus.dbg_state, bus.o_busy, bus.o_raddr, bus.o_rd_done, IDLE, RD_BASE);
      end else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_read_only();
    run_frame(1'b1, 1'b0, 1'b0, "read_only");
  endtask

  task automatic test_contention();
    run_frame(1'b1, 1'b1, 1'b0, "contention");
  endtask

  task automatic test_completion_noise();
    run_frame(1'b1, 1'b1, 1'b1, "noise");
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 3; i++) run_frame(1'b1, 1'($urandom_range(0, 1)), 1'b1, "random");
  endtask

  task automatic test_abort_mid_read();
    int seen, age;
    bit hit;
    seen = 0; age = 0; hit = 1'b0;
    @(negedge clk);
    bus.i_rd_req = 1'b1;
    bus.i_start  = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_read_complete = 1'b0;
      if (bus.o_re) begin
        age++;
        if (seen == 2) hit = 1'b1;
        else if (age == 2) begin
          bus.i_read_complete = 1'b1; seen++; age = 0;
        end
      end
    end
    n_checks++;
    if (!hit || bus.o_raddr !== RD_BASE + 32'h8) begin
      n_fail++; $display("FAIL abort_third_read: got hit=%b raddr=%h want 1/%h", hit, bus.o_raddr, RD_BASE + 32'h8);
    end else n_pass++;
    // abort, completion and start all in the same cycle
    bus.i_abort = 1'b1; bus.i_read_complete = 1'b1; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0; bus.i_read_complete = 1'b0; bus.i_start = 1'b0;
    n_checks++;
    if (bus.o_re !== 1'b0 || bus.dbg_state !== IDLE || bus.o_rd_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_next: got re=%b state=%0d done=%b busy=%b want 0/%0d/0/0",
        bus.o_re, bus.dbg_state, bus.o_rd_done, bus.o_busy, IDLE);
    end else n_pass++;
    n_checks++;
    if (bus.o_raddr !== RD_BASE || bus.dbg_rd_idx !== 32'd0) begin
      n_fail++; $display("FAIL abort_clear: got raddr=%h idx=%0d want %h/0", bus.o_raddr, bus.dbg_rd_idx, RD_BASE);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.o_rd_done !== 1'b0 || bus.dbg_state !== IDLE) begin
      n_fail++; $display("FAIL abort_settle: got done=%b state=%0d want 0/%0d", bus.o_rd_done, bus.dbg_state, IDLE);
    end else n_pass++;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_re !== 1'b1 || bus.o_raddr !== RD_BASE) begin
      n_fail++; $display("FAIL restart: got re=%b raddr=%h want 1/%h", bus.o_re, bus.o_raddr, RD_BASE);
    end else n_pass++;
    pulse_abort();
    drive_idle();
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.i_wr_req = 1'b1;
    bus.i_start  = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_we) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL wr_grant_timeout: got no o_we want o_we within 10 cycles");
    end else n_pass++;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n_checks++;
    if (bus.o_we !== 1'b1 || bus.dbg_state !== WR_BUSY || bus.o_waddr !== WR_BASE || bus.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL start_while_busy: got we=%b state=%0d waddr=%h busy=%b want 1/%0d/%h/1",
        bus.o_we, bus.dbg_state, bus.o_waddr, bus.o_busy, WR_BUSY, WR_BASE);
    end else n_pass++;
    #2 n_rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_we !== 1'b0 || bus.o_busy !== 1'b0 || bus.dbg_state !== IDLE) begin
      n_fail++; $display("FAIL async_reset: got we=%b busy=%b state=%0d want 0/0/%0d", bus.o_we, bus.o_busy, bus.dbg_state, IDLE);
    end else n_pass++;
    n_checks++;
    if ({bus.o_re, bus.o_rd_done, bus.o_wr_done, bus.o_frame_done} !== 4'b0 ||
        bus.o_raddr !== RD_BASE || bus.o_waddr !== WR_BASE) begin
      n_fail++; $display("FAIL reset_outputs: got flags=%b raddr=%h waddr=%h want 0000/%h/%h",
        {bus.o_re, bus.o_rd_done, bus.o_wr_done, bus.o_frame_done}, bus.o_raddr, bus.o_waddr, RD_BASE, WR_BASE);
    end else n_pass++;
    @(negedge clk);
    n_rst = 1'b0;
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.dbg_state !== IDLE || bus.o_busy !== 1'b0 || bus.o_we !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: got state=%0d busy=%b we=%b want %0d/0/0", bus.dbg_state, bus.o_busy, bus.o_we, IDLE);
    end else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_rst = 1'b1;
    drive_idle();
    test_reset();
    test_read_only();
    test_contention();
    test_completion_noise();
    test_random_frames();
    test_abort_mid_read();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
